button_seq_check: RTL

BUTTON_SEQ_CHECK -- requirements
Module: button_seq_check

---
 rtl/button_seq_check.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/button_seq_check.sv
// button_seq_check: checks a sequence of one-hot button presses against a
// loadable table of expected button indices, with a per-step timeout.
//
// Parameters:
//   NBTN    - number of one-hot button lines on click
//   DEPTH   - maximum sequence length (table entries)
//   TIMEOUT - cycles allowed per step while waiting for a press (>= 2)
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   en        - start request, sampled in IDLE only
//   len       - sequence length, latched as min(len, DEPTH) on start
//   load_we   - table write strobe (IDLE only)
//   load_addr - table entry to write
//   load_code - expected button index for that entry
//   click     - live (already synchronised) button levels
//   busy      - state is not IDLE
//   done      - one-cycle pulse when a sequence ends
//   pass      - last sequence fully correct
//   fail      - last sequence wrong or timed out
//   tmo       - last failure was a timeout
//   step      - correct presses so far in the current/last sequence
module button_seq_check #(
    parameter int unsigned NBTN    = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 50_000_000,
    localparam int unsigned CODE_W = $clog2(NBTN),
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned LEN_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [LEN_W-1:0]  len,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [CODE_W-1:0] load_code,
    input  logic [NBTN-1:0]   click,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              tmo,
    output logic [LEN_W-1:0]  step
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StArm, StWait, StPass, StFail} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  step_q, step_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              tmo_q, tmo_d;
    logic [CODE_W-1:0] code_tbl_q [DEPTH];

    logic [NBTN-1:0]   exp_onehot;
    logic [LEN_W-1:0]  step_inc;

    // An index >= NBTN shifts out to zero, so any nonzero click mismatches it.
    assign exp_onehot = NBTN'(1) << code_tbl_q[step_q[ADDR_W-1:0]];
    assign step_inc   = step_q + LEN_W'(1);

    // Expected-code table; writable only while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                code_tbl_q[i] <= '0;
            end
        end else if (load_we && state_q == StIdle) begin
            code_tbl_q[load_addr] <= load_code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            len_q   <= '0;
            timer_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            len_q   <= len_d;
            timer_q <= timer_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        len_d   = len_q;
        timer_d = timer_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            StIdle: begin
                if (en && len != '0) begin
                    state_d = StArm;
                    step_d  = '0;
                    timer_d = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    tmo_d   = 1'b0;
                    len_d   = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
                end
            end
            // Wait for all buttons released so a held press is never counted twice.
            StArm: begin
                if (click == '0) begin
                    state_d = StWait;
                    timer_d = '0;
                end
            end
            StWait: begin
                if (click == '0) begin
                    if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        state_d = StFail;
                        fail_d  = 1'b1;
                        tmo_d   = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end else if (click == exp_onehot) begin
                    step_d = step_inc;
                    if (step_inc == len_q) begin
                        state_d = StPass;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = StArm;
                    end
                end else begin
                    state_d = StFail;
                    fail_d  = 1'b1;
                end
            end
            StPass, StFail: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StPass) || (state_q == StFail);
    assign pass = pass_q;
    assign fail = fail_q;
    assign tmo  = tmo_q;
    assign step = step_q;

endmodule
